bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Two-port round-robin arbiter onto a strobed internal register bus.
// The winner's request is latched at grant; each access holds a strobe for ACCESS_CYCLES cycles.
module bus_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic        axi_aclk,
  input  logic        axi_areset,
  input  logic        h_req,
  input  logic        h_we,
  input  logic [15:0] h_addr,
  input  logic [31:0] h_wdata,
  output logic        h_ack,
  output logic [31:0] h_rdata,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [15:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic        l_ack,
  output logic [31:0] l_rdata,
  output logic [15:0] addressbus,
  output logic        readsignal,
  output logic        writesignal,
  output logic [31:0] databus_out,
  output logic        databus_oe,
  input  logic [31:0] databus_in,
  output logic        busy,
  output logic        grant_id
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  localparam logic [3:0] CNT_LAST = 4'(ACCESS_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        last_grant;
  logic        grant_q;
  logic        lat_we;
  logic [15:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] h_rdata_q, l_rdata_q;
  logic        winner;
  logic        grant_take;
  logic        cnt_done;
  logic        in_access;

  assign cnt_done   = (cnt == CNT_LAST);
  assign grant_take = (state == IDLE) && (h_req || l_req);

  always_comb begin
    winner    = l_req;
    state_nxt = state;
    // On a tie the port that did not win last time gets the bus.
    if (h_req && l_req)
      winner = ~last_grant;
    case (state)
      IDLE:    if (h_req || l_req) state_nxt = ACCESS;
      ACCESS:  if (cnt_done) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      cnt        <= '0;
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      h_rdata_q  <= '0;
      l_rdata_q  <= '0;
    end else begin
      if (grant_take) begin
        cnt        <= '0;
        grant_q    <= winner;
        last_grant <= winner;
        lat_we     <= winner ? l_we    : h_we;
        lat_addr   <= winner ? l_addr  : h_addr;
        lat_wdata  <= winner ? l_wdata : h_wdata;
      end else if (state == ACCESS && cnt != 4'hF) begin
        cnt <= cnt + 4'd1;
      end
      if (state == ACCESS && cnt_done && !lat_we) begin
        if (grant_q)
          l_rdata_q <= databus_in;
        else
          h_rdata_q <= databus_in;
      end
    end
  end

  assign in_access   = (state == ACCESS);
  assign readsignal  = in_access && !lat_we;
  assign writesignal = in_access && lat_we;
  assign databus_oe  = writesignal;
  assign databus_out = writesignal ? lat_wdata : '0;
  assign addressbus  = lat_addr;
  assign busy        = (state != IDLE);
  assign grant_id    = grant_q;
  assign h_ack       = (state == ACK) && !grant_q;
  assign l_ack       = (state == ACK) && grant_q;
  assign h_rdata     = h_rdata_q;
  assign l_rdata     = l_rdata_q;

endmodule
